// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: RV32I decode/issue stage feeding the ALU.
//   Decodes one instruction per cycle into ALU op code, operand A/B,
//   destination register, writeback enable, branch flag/condition and an
//   illegal-encoding flag, and holds the result in an ID/EX register.
//   A second (skid) entry absorbs the instruction accepted in the cycle the
//   output stalls, so in_ready_o can be a registered signal at full rate.
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   flush_i                     drop held and incoming instructions
//   in_valid_i / in_ready_o     upstream handshake (ready registered)
//   inst_i, pc_i, rs1/rs2_data_i  instruction, PC, register read data
//   ex_valid_o / ex_ready_i     downstream handshake
//   op_alu_o, opr_a_o, opr_b_o, rd_o, wr_en_o, branch_o,
//   br_funct3_o, illegal_o      issued entry payload
module id_ex_alu_issue #(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [OPW-1:0]  op_alu_o,
  output logic [XLEN-1:0] opr_a_o,
  output logic [XLEN-1:0] opr_b_o,
  output logic [4:0]      rd_o,
  output logic            wr_en_o,
  output logic            branch_o,
  output logic [2:0]      br_funct3_o,
  output logic            illegal_o
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h01);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'h03);
  localparam logic [OPW-1:0] OP_LSR  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_ASR  = OPW'(6'h06);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'h10);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(6'h29);
  localparam logic [OPW-1:0] OP_BGEU = OPW'(6'h31);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            wr;
    logic            br;
    logic [2:0]      f3;
    logic            ill;
  } ent_t;

  // Shared funct3 -> op mapping for OP and OP-IMM; alt selects SUB / ASR.
  function automatic logic [OPW-1:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SHL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_ASR : OP_LSR;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  ent_t       dec;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  always_comb begin
    dec    = '0;
    dec.rd = inst_i[11:7];
    dec.f3 = f3;
    legal  = 1'b0;
    case (opc)
      OPC_OP: begin
        legal  = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.op = f3_op(f3, f7[5]);
        dec.a  = rs1_data_i;
        dec.b  = rs2_data_i;
        dec.wr = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == F7_ZERO);
        else if (f3 == 3'b101) legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        else                   legal = 1'b1;
        dec.op = f3_op(f3, (f3 == 3'b101) && inst_i[30]);
        dec.a  = rs1_data_i;
        dec.b  = XLEN'($signed(inst_i[31:20]));
        dec.wr = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal  = 1'b1;
        dec.op = OP_ADD;
        dec.a  = (opc == OPC_AUIPC) ? pc_i : '0;
        dec.b  = XLEN'($signed({inst_i[31:12], 12'b0}));
        dec.wr = 1'b1;
      end
      OPC_BRANCH: begin
        legal  = (f3 != 3'b010) && (f3 != 3'b011);
        dec.op = (f3 == 3'b110) ? OP_SLTU : (f3 == 3'b111) ? OP_BGEU : OP_SUB;
        dec.a  = rs1_data_i;
        dec.b  = rs2_data_i;
        dec.br = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (dec.rd == 5'd0) dec.wr = 1'b0;
    // Illegal entries still issue, but carry a neutral, side-effect-free payload.
    if (!legal) begin
      dec.op  = OP_ADD;
      dec.a   = '0;
      dec.b   = '0;
      dec.wr  = 1'b0;
      dec.br  = 1'b0;
      dec.ill = 1'b1;
    end
  end

  ent_t out_q, out_d, sk_q, sk_d;
  logic out_vld_q, out_vld_d, sk_vld_q, sk_vld_d, rdy_q, rdy_d;
  logic accept;

  assign accept = in_valid_i && rdy_q;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sk_d      = sk_q;
    sk_vld_d  = sk_vld_q;
    if (flush_i) begin
      out_vld_d = 1'b0;
      sk_vld_d  = 1'b0;
    end else if (!out_vld_q || ex_ready_i) begin
      if (sk_vld_q) begin
        // Older skid entry goes out first; a same-cycle accept refills the skid.
        out_d     = sk_q;
        out_vld_d = 1'b1;
        sk_vld_d  = accept;
        if (accept) sk_d = dec;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      // Output stalled: ready was high, so the skid is known empty here.
      sk_d     = dec;
      sk_vld_d = 1'b1;
    end
    rdy_d = !sk_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q     <= '0;
      sk_q      <= '0;
      out_vld_q <= 1'b0;
      sk_vld_q  <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      out_q     <= out_d;
      sk_q      <= sk_d;
      out_vld_q <= out_vld_d;
      sk_vld_q  <= sk_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign ex_valid_o  = out_vld_q;
  assign op_alu_o    = out_q.op;
  assign opr_a_o     = out_q.a;
  assign opr_b_o     = out_q.b;
  assign rd_o        = out_q.rd;
  assign wr_en_o     = out_q.wr;
  assign branch_o    = out_q.br;
  assign br_funct3_o = out_q.f3;
  assign illegal_o   = out_q.ill;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n_i, flush_i, in_valid_i, ex_ready_i;
  logic [31:0] inst_i, pc_i, rs1_data_i, rs2_data_i;
  logic        in_ready_o, ex_valid_o, wr_en_o, branch_o, illegal_o;
  logic [5:0]  op_alu_o;
  logic [31:0] opr_a_o, opr_b_o;
  logic [4:0]  rd_o;
  logic [2:0]  br_funct3_o;

  id_ex_alu_issue #(.XLEN(32), .OPW(6)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .op_alu_o(op_alu_o), .opr_a_o(opr_a_o), .opr_b_o(opr_b_o), .rd_o(rd_o),
    .wr_en_o(wr_en_o), .branch_o(branch_o), .br_funct3_o(br_funct3_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wr, br, ill;
    logic [2:0]  f3;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t mq[$];        // entries held by the stage, oldest first (at most 2)
  logic m_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference decode, written from the instruction-set rules with a lookup table.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [5:0] tab [8];
    exp_t e;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    tab = '{6'h00, 6'h02, 6'h03, 6'h29, 6'h20, 6'h04, 6'h08, 6'h10};
    f3 = inst[14:12];
    f7 = inst[31:25];
    e = '{op: 6'h00, a: 32'd0, b: 32'd0, rd: inst[11:7], wr: 1'b0, br: 1'b0, ill: 1'b0, f3: f3};
    ok = 1'b0;
    if (inst[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op = tab[f3];
      if (f7 == 7'h20) e.op = (f3 == 3'd0) ? 6'h01 : 6'h06;
      e.a = r1; e.b = r2; e.wr = 1'b1;
    end else if (inst[6:0] == 7'h13) begin
      ok = 1'b1;
      if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      e.op = (f3 == 3'd5 && f7 == 7'h20) ? 6'h06 : tab[f3];
      e.a = r1; e.b = {{20{inst[31]}}, inst[31:20]}; e.wr = 1'b1;
    end else if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17) begin
      ok = 1'b1;
      e.a = (inst[6:0] == 7'h17) ? pc : 32'd0;
      e.b = {inst[31:12], 12'd0}; e.wr = 1'b1;
    end else if (inst[6:0] == 7'h63) begin
      ok = !(f3 == 3'd2 || f3 == 3'd3);
      e.op = (f3 == 3'd6) ? 6'h29 : (f3 == 3'd7) ? 6'h31 : 6'h01;
      e.a = r1; e.b = r2; e.br = 1'b1;
    end
    if (e.rd == 5'd0) e.wr = 1'b0;
    if (!ok) begin
      e.op = 6'h00; e.a = 32'd0; e.b = 32'd0; e.wr = 1'b0; e.br = 1'b0; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic check_model();
    exp_t h;
    chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, m_ready});
    if (mq.size() > 0) begin
      h = mq[0];
      chk("op", {26'd0, op_alu_o}, {26'd0, h.op});
      chk("opr_a", opr_a_o, h.a);
      chk("opr_b", opr_b_o, h.b);
      chk("rd", {27'd0, rd_o}, {27'd0, h.rd});
      chk("wr_en", {31'd0, wr_en_o}, {31'd0, h.wr});
      chk("branch", {31'd0, branch_o}, {31'd0, h.br});
      chk("funct3", {29'd0, br_funct3_o}, {29'd0, h.f3});
      chk("illegal", {31'd0, illegal_o}, {31'd0, h.ill});
    end
  endtask

  // Called on a falling edge: apply inputs for the next rising edge, advance
  // the model through that edge, then check on the following falling edge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic exr, input logic fl);
    in_valid_i = v; inst_i = inst; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    ex_ready_i = exr; flush_i = fl;
    if (fl) mq.delete();
    else begin
      if (mq.size() > 0 && exr) void'(mq.pop_front());
      if (v && m_ready) mq.push_back(ref_decode(inst, pc, r1, r2));
    end
    m_ready = (mq.size() < 2);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
      3, 4: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7, 8: w[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; ex_ready_i = 1'b0;
    inst_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    @(negedge clk); @(negedge clk);
    // Reset state
    chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_op", {26'd0, op_alu_o}, 32'h00);
    chk("rst_a", opr_a_o, 32'd0);
    chk("rst_b", opr_b_o, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk);

    // Decode sweep
    drive(1, 32'h40208033, 32'h100, 32'd5, 32'd3, 1, 0);
    chk("sub_op", {26'd0, op_alu_o}, 32'h01);
    chk("sub_a", opr_a_o, 32'd5);
    chk("sub_b", opr_b_o, 32'd3);
    chk("sub_rd", {27'd0, rd_o}, 32'd0);
    chk("sub_wr", {31'd0, wr_en_o}, 32'd0);
    drive(1, 32'hFFF0A093, 32'h104, 32'd7, 32'd9, 1, 0);
    chk("slti_op", {26'd0, op_alu_o}, 32'h03);
    chk("slti_b", opr_b_o, 32'hFFFFFFFF);
    chk("slti_wr", {31'd0, wr_en_o}, 32'd1);
    drive(1, 32'h12345037, 32'h108, 32'd7, 32'd9, 1, 0);
    chk("lui_op", {26'd0, op_alu_o}, 32'h00);
    chk("lui_a", opr_a_o, 32'd0);
    chk("lui_b", opr_b_o, 32'h12345000);
    drive(1, 32'h0020F063, 32'h10C, 32'd1, 32'd2, 1, 0);
    chk("bgeu_op", {26'd0, op_alu_o}, 32'h31);
    chk("bgeu_br", {31'd0, branch_o}, 32'd1);
    chk("bgeu_f3", {29'd0, br_funct3_o}, 32'd7);
    chk("bgeu_wr", {31'd0, wr_en_o}, 32'd0);
    drive(1, 32'h0020E063, 32'h110, 32'd1, 32'd2, 1, 0);
    chk("bltu_op", {26'd0, op_alu_o}, 32'h29);
    drive(1, 32'h0020C063, 32'h114, 32'd1, 32'd2, 1, 0);
    chk("blt_op", {26'd0, op_alu_o}, 32'h01);
    drive(1, 32'h0000007F, 32'h118, 32'd1, 32'd2, 1, 0);
    chk("ill_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("ill_flag", {31'd0, illegal_o}, 32'd1);
    chk("ill_wr", {31'd0, wr_en_o}, 32'd0);
    chk("ill_a", opr_a_o, 32'd0);
    chk("ill_b", opr_b_o, 32'd0);
    drive(1, 32'h40009093, 32'h11C, 32'd1, 32'd2, 1, 0);
    chk("slli_ill", {31'd0, illegal_o}, 32'd1);
    drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

    // Backpressure: I0..I3 with execute stalled for three cycles
    drive(1, 32'h00100093, 32'h200, 32'd0, 32'd0, 1, 0);  // I0 accepted
    drive(1, 32'h00200113, 32'h204, 32'd0, 32'd0, 0, 0);  // I1 into skid
    chk("bp_ready_drop", {31'd0, in_ready_o}, 32'd0);
    drive(1, 32'h00300193, 32'h208, 32'd0, 32'd0, 0, 0);  // I2 held off
    drive(1, 32'h00300193, 32'h208, 32'd0, 32'd0, 0, 0);
    drive(1, 32'h00300193, 32'h208, 32'd0, 32'd0, 1, 0);  // I0 out, I1 moves up
    chk("bp_i1_rd", {27'd0, rd_o}, 32'd2);
    drive(1, 32'h00300193, 32'h208, 32'd0, 32'd0, 1, 0);  // I2 accepted
    drive(1, 32'h00400213, 32'h20C, 32'd0, 32'd0, 1, 0);  // I3 accepted
    drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    chk("bp_i3_rd", {27'd0, rd_o}, 32'd4);
    drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

    // Flush with both entries full and a new instruction presented
    drive(1, 32'h00500293, 32'h300, 32'd0, 32'd0, 1, 0);
    drive(1, 32'h00600313, 32'h304, 32'd0, 32'd0, 0, 0);
    drive(1, 32'h00700393, 32'h308, 32'd0, 32'd0, 0, 1);
    chk("flush_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
    drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    chk("flush_gone", {31'd0, ex_valid_o}, 32'd0);

    // Asynchronous reset while an entry is valid
    drive(1, 32'h00800413, 32'h400, 32'd0, 32'd0, 0, 0);
    chk("pre_rst_valid", {31'd0, ex_valid_o}, 32'd1);
    in_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("async_rst_op", {26'd0, op_alu_o}, 32'h00);
    mq.delete();
    m_ready = 1'b1;
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    drive(1, 32'h00A00513, 32'h500, 32'd0, 32'd0, 1, 0);
    chk("post_rst_first", {31'd0, ex_valid_o}, 32'd1);

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- Decode/issue stage that produces the ALU control and operand interface for the execute stage: op code, operand A, operand B, plus writeback and branch side-band.
- Accepts one fetched RV32I instruction per cycle with its PC and register-file read data.
- Decodes it and holds the result in an ID/EX pipeline register.
- A 2-entry skid buffer keeps full throughput while upstream ready is a registered signal.

Parameters:
- XLEN, 32, datapath width of operands and PC.
- OPW, 6, ALU op-code width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  discard all held and incoming instructions.
- in_valid_i  input  1  instruction/operands valid.
- in_ready_o  output  1  stage can accept; registered.
- inst_i  input  32  instruction word.
- pc_i  input  XLEN  instruction PC.
- rs1_data_i  input  XLEN  register-file rs1 read data, same cycle as inst_i.
- rs2_data_i  input  XLEN  register-file rs2 read data, same cycle as inst_i.
- ex_valid_o  output  1  execute-side entry valid.
- ex_ready_i  input  1  execute stage consumes the entry this cycle.
- op_alu_o  output  OPW  ALU op code.
- opr_a_o  output  XLEN  ALU operand A.
- opr_b_o  output  XLEN  ALU operand B.
- rd_o  output  5  destination register.
- wr_en_o  output  1  register writeback enable.
- branch_o  output  1  conditional branch.
- br_funct3_o  output  3  branch condition, inst[14:12].
- illegal_o  output  1  unsupported encoding.

Behaviour:
- Reset: ex_valid_o=0, skid entry invalid, in_ready_o=1; all payload outputs 0, so op_alu_o=ADD.
- Op codes follow the shared ALU op-code defines: ADD=6'h00, SUB=6'h01, SHL=6'h02, SLT=6'h03, LSR=6'h04, ASR=6'h06, OR=6'h08, AND=6'h10, NOR=6'h18, XOR=6'h20, SLTU=6'h29, BGEU=6'h31.
- Decode is combinational from inst_i and registered on accept. Latency is 1 cycle from accept to ex_valid_o.
- OP (0110011): a=rs1, b=rs2.
  - funct3 000: ADD, or SUB when funct7=0100000.
  - 001 SHL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: LSR, or ASR when funct7=0100000.
  - 110 OR, 111 AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): same mapping, but no SUB; a=rs1, b=sign-extended inst[31:20].
  - SRAI when inst[30]=1.
  - SLLI/SRLI with inst[31:25] not 0000000, or SRAI with inst[31:25] not 0100000, is illegal.
- LUI (0110111): ADD, a=0, b={inst[31:12],12'b0}.
- AUIPC (0010111): ADD, a=pc_i, b={inst[31:12],12'b0}.
- BRANCH (1100011): a=rs1, b=rs2, branch_o=1, wr_en_o=0.
  - BEQ/BNE/BLT/BGE map to SUB.
  - BLTU maps to SLTU; BGEU maps to BGEU.
  - funct3 010/011 is illegal.
- Writeback: wr_en_o=1 for OP/OP-IMM/LUI/AUIPC when rd≠0; rd_o=inst[11:7] always.
- Illegal or any other opcode:
  - illegal_o=1, op=ADD, a=b=0, wr_en_o=0, branch_o=0.
  - The entry is still issued with ex_valid_o=1 so the exception reaches execute in order.
- Accept occurs when in_valid_i && in_ready_o.
  - Output register empty, or ex_ready_i=1 with no skid entry: the decoded entry goes to the output register.
  - Otherwise it goes to the skid entry.
- When ex_ready_i=1 and the skid entry is valid, the skid entry moves to the output register. A simultaneous accept then goes to the skid entry, so ordering is preserved.
- in_ready_o next = !(skid valid next).
  - A cycle with an accept while the output is stalled drops ready on the following cycle.
- ex_valid_o/payload hold stable while ex_valid_o && !ex_ready_i.
- flush_i has priority over every other event. On the next edge:
  - ex_valid_o=0 and the skid entry is invalid.
  - in_ready_o=1.
  - Any instruction presented in the flush cycle is discarded.
  - Payload registers need not clear.
- Reset asserted mid-operation clears both entries immediately and asynchronously; no partial entry survives.
- Back-to-back throughput: 1 instruction/cycle while ex_ready_i=1.

Test Plan:
- Reset: rst_n_i low mid-stream with ex_valid_o=1 -> ex_valid_o=0, in_ready_o=1, op_alu_o=6'h00 immediately; first accept after release appears 1 cycle later.
- Decode sweep:
  - inst 0x40208033 (sub x0,x1,x2), rs1=5, rs2=3 -> op=6'h01, a=5, b=3, rd=0, wr_en=0.
  - inst 0xFFF0A093 (slti x1,x1,-1) -> op=6'h03, b=0xFFFFFFFF, wr_en=1.
  - inst 0x12345037 (lui x0) -> op=6'h00, a=0, b=0x12345000.
- Branches:
  - bgeu 0x0020F063 -> op=6'h31, branch_o=1, br_funct3=111, wr_en=0.
  - bltu 0x0020E063 -> op=6'h29.
  - blt 0x0020C063 -> op=6'h01.
- Illegal:
  - 0x0000007F -> ex_valid=1, illegal_o=1, wr_en=0, a=b=0.
  - slli with inst[31:25]=0100000 -> illegal_o=1.
- Backpressure: stream I0..I3 with ex_ready_i=0 for cycles 2-4.
  - in_ready_o falls one cycle after the skid fills.
  - No instruction is lost or duplicated; ex order is I0,I1,I2,I3.
  - Full rate resumes once ex_ready_i=1.
- Flush with both entries valid and in_valid_i=1 -> next cycle ex_valid_o=0, in_ready_o=1, and the flushed-cycle instruction never appears.
